line_nav_ctrl: RTL and testbench

LINE_NAV_CTRL -- requirements
Module: line_nav_ctrl

---
 rtl/line_nav_ctrl_if.sv | 29 ++
 rtl/line_nav_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_line_nav_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/line_nav_ctrl_if.sv
// Bus bundle for line_nav_ctrl: sensors, command handshake, PWM duty and motor/status outputs.
// master = controller driver (testbench or host), slave = line_nav_ctrl.
interface line_nav_ctrl_if #(
  parameter int N_SENS = 5,
  parameter int PWM_W  = 8
);
  logic [N_SENS-1:0] ips;
  logic [2:0]        cmd;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [PWM_W-1:0]  duty;
  logic              fora;
  logic              bcka;
  logic              forb;
  logic              bckb;
  logic              busy;
  logic              fault;
  logic              junction;

  modport master (
    output ips, cmd, cmd_valid, duty,
    input  cmd_ready, fora, bcka, forb, bckb, busy, fault, junction
  );

  modport slave (
    input  ips, cmd, cmd_valid, duty,
    output cmd_ready, fora, bcka, forb, bckb, busy, fault, junction
  );
endinterface

// File: rtl/line_nav_ctrl.sv
// Line-following two-wheel navigation controller with per-sensor debounce, queued turns and turn timeout.
// Optional macro LINE_NAV_PWM_EN gates FORWARD/REVERSE drives with a duty-cycle PWM.
module line_nav_ctrl #(
  parameter int N_SENS  = 5,
  parameter int DEB_CYC = 4,
  parameter int TMO_CYC = 1000000,
  parameter int PWM_W   = 8
) (
  input logic            clk,
  input logic            reset,
  line_nav_ctrl_if.slave bus
);

  localparam int CENTRE = N_SENS / 2;
  localparam int DEB_W  = $clog2(DEB_CYC + 1);
  localparam int TMO_W  = $clog2(TMO_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  localparam logic [2:0] CMD_STOP   = 3'd0;
  localparam logic [2:0] CMD_FWD    = 3'd1;
  localparam logic [2:0] CMD_TURN_L = 3'd2;
  localparam logic [2:0] CMD_TURN_R = 3'd3;
  localparam logic [2:0] CMD_SPIN   = 3'd4;
  localparam logic [2:0] CMD_REV    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_FORWARD, S_CORR_L, S_CORR_R, S_TURN_L, S_TURN_R, S_SPIN, S_REVERSE, S_FAULT
  } state_t;

  typedef enum logic [1:0] { PEND_NONE, PEND_L, PEND_R } pend_t;

  state_t            state_q, state_d;
  pend_t             pend_q, pend_d;
  logic              phase_q, phase_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [N_SENS-1:0] filt_q, filtPrev_q;
  logic [DEB_W-1:0]  debCnt_q [N_SENS];
  logic [3:0]        drive_q, drive_d;
  logic              busy_q, fault_q, junction_q;

  logic centre, innerL, innerR, allOff, edgeL, edgeR;
  logic cmdReady, accept, cmdTaken, pwmOn;

  assign centre   = filt_q[CENTRE];
  assign innerL   = |filt_q[N_SENS-2:CENTRE+1];
  assign innerR   = |filt_q[CENTRE-1:1];
  assign allOff   = ~|filt_q;
  assign edgeL    = filt_q[N_SENS-1] & ~filtPrev_q[N_SENS-1];
  assign edgeR    = filt_q[0] & ~filtPrev_q[0];
  assign cmdReady = state_q inside {S_IDLE, S_FORWARD, S_REVERSE, S_FAULT};
  assign accept   = bus.cmd_valid & cmdReady;

  // A filtered bit only follows its raw input after DEB_CYC disagreeing samples in a row.
  always_ff @(posedge clk) begin
    if (!reset) begin
      filt_q     <= '0;
      filtPrev_q <= '0;
      for (int i = 0; i < N_SENS; i++) debCnt_q[i] <= '0;
    end else begin
      filtPrev_q <= filt_q;
      for (int i = 0; i < N_SENS; i++) begin
        if (bus.ips[i] == filt_q[i]) begin
          debCnt_q[i] <= '0;
        end else if (debCnt_q[i] == DEB_LAST) begin
          filt_q[i]   <= bus.ips[i];
          debCnt_q[i] <= '0;
        end else begin
          debCnt_q[i] <= debCnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    phase_d  = phase_q;
    tmo_d    = tmo_q;
    cmdTaken = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (bus.cmd)
            CMD_FWD:    state_d = S_FORWARD;
            CMD_TURN_L: begin pend_d = PEND_L; state_d = S_FORWARD; end
            CMD_TURN_R: begin pend_d = PEND_R; state_d = S_FORWARD; end
            CMD_SPIN:   state_d = S_SPIN;
            CMD_REV:    state_d = S_REVERSE;
            default:    ;
          endcase
        end
      end
      S_FORWARD: begin
        // A command that changes something suppresses this cycle's sensor reaction.
        if (accept) begin
          case (bus.cmd)
            CMD_STOP:   begin state_d = S_IDLE;    cmdTaken = 1'b1; end
            CMD_TURN_L: begin pend_d = PEND_L;     cmdTaken = 1'b1; end
            CMD_TURN_R: begin pend_d = PEND_R;     cmdTaken = 1'b1; end
            CMD_SPIN:   begin state_d = S_SPIN;    cmdTaken = 1'b1; end
            CMD_REV:    begin state_d = S_REVERSE; cmdTaken = 1'b1; end
            default:    ;
          endcase
        end
        if (!cmdTaken) begin
          if (allOff) begin
            state_d = S_IDLE;
          end else if (pend_q == PEND_L && edgeL) begin
            state_d = S_TURN_L;
            pend_d  = PEND_NONE;
          end else if (pend_q == PEND_R && edgeR) begin
            state_d = S_TURN_R;
            pend_d  = PEND_NONE;
          end else if (!centre && innerL) begin
            state_d = S_CORR_L;
          end else if (!centre && innerR) begin
            state_d = S_CORR_R;
          end
        end
      end
      S_CORR_L: begin
        if (allOff) state_d = S_IDLE;
        else if (centre && !innerL) state_d = S_FORWARD;
      end
      S_CORR_R: begin
        if (allOff) state_d = S_IDLE;
        else if (centre && !innerR) state_d = S_FORWARD;
      end
      S_TURN_L, S_TURN_R, S_SPIN: begin
        // Phase 0 leaves the current line, phase 1 reacquires the next one.
        tmo_d = tmo_q + 1'b1;
        if (phase_q && centre) state_d = (state_q == S_SPIN) ? S_IDLE : S_FORWARD;
        else if (tmo_q == TMO_LAST) state_d = S_FAULT;
        else if (!phase_q && !centre) phase_d = 1'b1;
      end
      S_REVERSE, S_FAULT: begin
        if (accept && bus.cmd == CMD_STOP) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if ((state_d inside {S_TURN_L, S_TURN_R, S_SPIN}) && state_d != state_q) begin
      phase_d = 1'b0;
      tmo_d   = '0;
    end
    if (state_d == S_IDLE) pend_d = PEND_NONE;
  end

  function automatic logic [3:0] motorBits(state_t s);
    case (s)
      S_FORWARD:        motorBits = 4'b1010;
      S_CORR_L:         motorBits = 4'b0010;
      S_CORR_R:         motorBits = 4'b1000;
      S_TURN_L:         motorBits = 4'b0110;
      S_TURN_R, S_SPIN: motorBits = 4'b1001;
      S_REVERSE:        motorBits = 4'b0101;
      default:          motorBits = 4'b0000;
    endcase
  endfunction

`ifdef LINE_NAV_PWM_EN
  logic [PWM_W-1:0] pwm_q, pwm_d;
  assign pwm_d = pwm_q + 1'b1;
  assign pwmOn = pwm_d < bus.duty;

  always_ff @(posedge clk) begin
    if (!reset) pwm_q <= '0;
    else pwm_q <= pwm_d;
  end
`else
  assign pwmOn = 1'b1;
`endif

  assign drive_d = ((state_d inside {S_FORWARD, S_REVERSE}) && !pwmOn) ? 4'b0000 : motorBits(state_d);

  // Outputs are registered from the next state so they always reflect the state register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pend_q     <= PEND_NONE;
      phase_q    <= 1'b0;
      tmo_q      <= '0;
      drive_q    <= '0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      junction_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      phase_q    <= phase_d;
      tmo_q      <= tmo_d;
      drive_q    <= drive_d;
      busy_q     <= !(state_d inside {S_IDLE, S_FAULT});
      fault_q    <= state_d == S_FAULT;
      junction_q <= (state_q == S_FORWARD) && (edgeL || edgeR);
    end
  end

  assign {bus.fora, bus.bcka, bus.forb, bus.bckb} = drive_q;
  assign bus.busy      = busy_q;
  assign bus.fault     = fault_q;
  assign bus.junction  = junction_q;
  assign bus.cmd_ready = cmdReady;

endmodule

// File: tb/tb_line_nav_ctrl.sv
// Self-checking bench for line_nav_ctrl: directed scenarios then randomized sensor/command traffic
// compared cycle by cycle against a behavioural model (honours LINE_NAV_PWM_EN when defined).
module tb_line_nav_ctrl;
  localparam int N_SENS  = 5;
  localparam int DEB_CYC = 4;
  localparam int TMO_CYC = 64;
  localparam int PWM_W   = 8;

  localparam logic [2:0] C_STOP = 3'd0, C_FWD = 3'd1, C_TL = 3'd2, C_TR = 3'd3, C_SPIN = 3'd4;

  localparam int M_IDLE = 0, M_FWD = 1, M_CL = 2, M_CR = 3, M_TL = 4, M_TR = 5,
                 M_SPIN = 6, M_REV = 7, M_FAULT = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  initial forever #5 clk = ~clk;

  line_nav_ctrl_if #(.N_SENS(N_SENS), .PWM_W(PWM_W)) bus ();

  line_nav_ctrl #(
    .N_SENS(N_SENS), .DEB_CYC(DEB_CYC), .TMO_CYC(TMO_CYC), .PWM_W(PWM_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int                 mState, mPend, mPhase, mTmo, mPwm;
  logic [N_SENS-1:0]  mF, mFPrev;
  logic [DEB_CYC-1:0] mHist [N_SENS];
  logic [3:0]         expDrive;
  logic               expBusy, expFault, expJunc;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h required %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit modelReady();
    return mState == M_IDLE || mState == M_FWD || mState == M_REV || mState == M_FAULT;
  endfunction

  // Wheel direction per state: +1 forward, -1 backward, 0 stopped.
  function automatic int leftWheel(int st);
    case (st)
      M_FWD, M_CR, M_TR, M_SPIN: return 1;
      M_TL, M_REV:               return -1;
      default:                   return 0;
    endcase
  endfunction

  function automatic int rightWheel(int st);
    case (st)
      M_FWD, M_CL, M_TL:      return 1;
      M_TR, M_SPIN, M_REV:    return -1;
      default:                return 0;
    endcase
  endfunction

  task automatic stepModel();
    logic [N_SENS-1:0] raw;
    bit edgeL, edgeR, acc, allOff, ctr, inL, inR, taken;
    int nxt, l, r;
    raw = bus.ips;
    if (!reset) begin
      mState = M_IDLE; mPend = 0; mPhase = 0; mTmo = 0; mPwm = 0;
      mF = '0; mFPrev = '0;
      for (int i = 0; i < N_SENS; i++) mHist[i] = '0;
      expDrive = 4'b0000; expBusy = 1'b0; expFault = 1'b0; expJunc = 1'b0;
      return;
    end
    edgeL  = mF[N_SENS-1] && !mFPrev[N_SENS-1];
    edgeR  = mF[0] && !mFPrev[0];
    acc    = bus.cmd_valid && modelReady();
    allOff = (mF == '0);
    ctr    = mF[N_SENS/2];
    inL    = |mF[N_SENS-2:N_SENS/2+1];
    inR    = |mF[N_SENS/2-1:1];
    expJunc = (mState == M_FWD) && (edgeL || edgeR);
    nxt = mState;
    case (mState)
      M_IDLE, M_FWD: begin
        taken = 1'b0;
        if (acc) begin
          taken = 1'b1;
          case (bus.cmd)
            3'd0: nxt = M_IDLE;
            3'd1: begin nxt = M_FWD; taken = (mState == M_IDLE); end
            3'd2: begin mPend = 1; nxt = M_FWD; end
            3'd3: begin mPend = 2; nxt = M_FWD; end
            3'd4: nxt = M_SPIN;
            3'd5: nxt = M_REV;
            default: taken = 1'b0;
          endcase
        end
        if (mState == M_FWD && !taken) begin
          if (allOff) nxt = M_IDLE;
          else if (mPend == 1 && edgeL) begin nxt = M_TL; mPend = 0; end
          else if (mPend == 2 && edgeR) begin nxt = M_TR; mPend = 0; end
          else if (!ctr && inL) nxt = M_CL;
          else if (!ctr && inR) nxt = M_CR;
        end
      end
      M_CL: if (allOff) nxt = M_IDLE; else if (ctr && !inL) nxt = M_FWD;
      M_CR: if (allOff) nxt = M_IDLE; else if (ctr && !inR) nxt = M_FWD;
      M_TL, M_TR, M_SPIN: begin
        if (mPhase == 1 && ctr) nxt = (mState == M_SPIN) ? M_IDLE : M_FWD;
        else if (mTmo == TMO_CYC - 1) nxt = M_FAULT;
        else begin
          mTmo++;
          if (!ctr) mPhase = 1;
        end
      end
      default: if (acc && bus.cmd == 3'd0) nxt = M_IDLE;
    endcase
    if ((nxt == M_TL || nxt == M_TR || nxt == M_SPIN) && nxt != mState) begin
      mPhase = 0;
      mTmo   = 0;
    end
    if (nxt == M_IDLE) mPend = 0;
    mState = nxt;
    mFPrev = mF;
    for (int i = 0; i < N_SENS; i++) begin
      mHist[i] = {mHist[i][DEB_CYC-2:0], raw[i]};
      if (mHist[i] == {DEB_CYC{~mF[i]}}) mF[i] = ~mF[i];
    end
    mPwm = (mPwm + 1) % (1 << PWM_W);
    l = leftWheel(mState);
    r = rightWheel(mState);
    expDrive = {l > 0, l < 0, r > 0, r < 0};
`ifdef LINE_NAV_PWM_EN
    if ((mState == M_FWD || mState == M_REV) && !(mPwm < int'(bus.duty))) expDrive = 4'b0000;
`endif
    expBusy  = !(mState == M_IDLE || mState == M_FAULT);
    expFault = (mState == M_FAULT);
  endtask

  task automatic tick();
    @(posedge clk);
    stepModel();
    @(negedge clk);
    checkOutput("cmd_ready", 32'(bus.cmd_ready), 32'(modelReady()));
    checkOutput("drive", 32'({bus.fora, bus.bcka, bus.forb, bus.bckb}), 32'(expDrive));
    checkOutput("busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("fault", 32'(bus.fault), 32'(expFault));
    checkOutput("junction", 32'(bus.junction), 32'(expJunc));
  endtask

  task automatic applyStimulus(input logic [N_SENS-1:0] ipsV, input logic [2:0] cmdV,
                               input logic validV, input int n);
    bus.ips       = ipsV;
    bus.cmd       = cmdV;
    bus.cmd_valid = validV;
    repeat (n) tick();
  endtask

  function automatic logic [31:0] driveNow();
    return 32'({bus.fora, bus.bcka, bus.forb, bus.bckb});
  endfunction

  logic [N_SENS-1:0] pats [12] = '{5'b00100, 5'b00110, 5'b01100, 5'b00010, 5'b01000, 5'b00001,
                                   5'b10000, 5'b00000, 5'b00111, 5'b11100, 5'b00101, 5'b10100};

  initial begin
    int highCnt;
    logic [N_SENS-1:0] ipsV;
    int hold;
    reset         = 1'b0;
    bus.ips       = 5'b00100;
    bus.cmd       = C_STOP;
    bus.cmd_valid = 1'b0;
    bus.duty      = 8'd64;
    tick();
    tick();
    checkOutput("rst_drive", driveNow(), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_fault", 32'(bus.fault), 32'd0);
    reset = 1'b1;

    applyStimulus(5'b00100, C_STOP, 1'b0, 6);
    applyStimulus(5'b00100, C_FWD, 1'b1, 1);
    checkOutput("fwd_busy", 32'(bus.busy), 32'd1);
    applyStimulus(5'b00100, C_STOP, 1'b0, 2);

    applyStimulus(5'b00110, C_STOP, 1'b0, 3);
    applyStimulus(5'b00100, C_STOP, 1'b0, 2);
    checkOutput("glitch_busy", 32'(bus.busy), 32'd1);
    applyStimulus(5'b00010, C_STOP, 1'b0, 5);
    checkOutput("corr_r_drive", driveNow(), 32'b1000);

    applyStimulus(5'b00100, C_STOP, 1'b0, 5);
    applyStimulus(5'b00100, C_TR, 1'b1, 1);
    applyStimulus(5'b00101, C_STOP, 1'b0, 5);
    checkOutput("junction_pulse", 32'(bus.junction), 32'd1);
    checkOutput("turn_r_drive", driveNow(), 32'b1001);
    applyStimulus(5'b00101, C_STOP, 1'b0, 1);
    checkOutput("junction_single", 32'(bus.junction), 32'd0);
    applyStimulus(5'b00001, C_STOP, 1'b0, 5);
    applyStimulus(5'b00100, C_STOP, 1'b0, 6);
    checkOutput("turn_exit_busy", 32'(bus.busy), 32'd1);
    checkOutput("turn_exit_bckb", 32'(bus.bckb), 32'd0);

    applyStimulus(5'b00100, C_SPIN, 1'b1, 1);
    applyStimulus(5'b00100, C_STOP, 1'b0, TMO_CYC - 1);
    checkOutput("spin_pre_fault", 32'(bus.fault), 32'd0);
    checkOutput("spin_drive", driveNow(), 32'b1001);
    applyStimulus(5'b00100, C_STOP, 1'b0, 1);
    checkOutput("spin_fault", 32'(bus.fault), 32'd1);
    checkOutput("fault_drive", driveNow(), 32'd0);
    applyStimulus(5'b00100, C_TL, 1'b1, 1);
    checkOutput("fault_sticky", 32'(bus.fault), 32'd1);
    applyStimulus(5'b00100, C_STOP, 1'b1, 1);
    checkOutput("fault_clear", 32'(bus.fault), 32'd0);
    checkOutput("stop_busy", 32'(bus.busy), 32'd0);

    applyStimulus(5'b00100, C_FWD, 1'b1, 1);
    highCnt = 0;
    for (int k = 0; k < 256; k++) begin
      applyStimulus(5'b00100, C_STOP, 1'b0, 1);
      highCnt += int'(bus.fora);
    end
`ifdef LINE_NAV_PWM_EN
    checkOutput("pwm_high", 32'(highCnt), 32'd64);
`else
    checkOutput("pwm_high", 32'(highCnt), 32'd256);
`endif

    for (int k = 0; k < 400; k++) begin
      ipsV = ($urandom_range(0, 9) == 0) ? N_SENS'($urandom) : pats[$urandom_range(0, 11)];
      hold = int'($urandom_range(1, 10));
      for (int c = 0; c < hold; c++) begin
        reset    = ($urandom_range(0, 299) != 0);
        bus.duty = PWM_W'($urandom);
        applyStimulus(ipsV, 3'($urandom_range(0, 7)), ($urandom_range(0, 4) == 0), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
